// File: rtl/m_axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite master and its watchdog.
package m_axi_lite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/m_axi_lite_wdog.sv
// Transaction watchdog: counts idle cycles of a busy transaction and flags expiry.
// Only instantiated when M_AXI_LITE_TIMEOUT_EN is defined.
module m_axi_lite_wdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Held at zero outside busy states, so entry from IDLE starts from zero and
  // state-to-state entries always coincide with a handshake clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || !active) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // A handshake in the expiry cycle wins: progress is never aborted.
  assign expired = active && !clear && (count == LIMIT);

endmodule

// File: rtl/m_axi_lite_master.sv
// AXI4-Lite master: one outstanding single-beat read or write per command,
// registered AXI outputs. Optional watchdog abort via `define M_AXI_LITE_TIMEOUT_EN.
module m_axi_lite_master
  import m_axi_lite_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                M_AXI_ACLK,
  input  logic                M_AXI_ARESETN,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,

  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,

  output logic [ADDR_W-1:0]   M_AXI_LITE_AWADDR,
  output logic [2:0]          M_AXI_LITE_AWPROT,
  output logic                M_AXI_LITE_AWVALID,
  input  logic                M_AXI_LITE_AWREADY,

  output logic [DATA_W-1:0]   M_AXI_LITE_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_LITE_WSTRB,
  output logic                M_AXI_LITE_WVALID,
  input  logic                M_AXI_LITE_WREADY,

  input  logic [1:0]          M_AXI_LITE_BRESP,
  input  logic                M_AXI_LITE_BVALID,
  output logic                M_AXI_LITE_BREADY,

  output logic [ADDR_W-1:0]   M_AXI_LITE_ARADDR,
  output logic [2:0]          M_AXI_LITE_ARPROT,
  output logic                M_AXI_LITE_ARVALID,
  input  logic                M_AXI_LITE_ARREADY,

  input  logic [DATA_W-1:0]   M_AXI_LITE_RDATA,
  input  logic [1:0]          M_AXI_LITE_RRESP,
  input  logic                M_AXI_LITE_RVALID,
  output logic                M_AXI_LITE_RREADY
);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("m_axi_lite_master: DATA_W must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("m_axi_lite_master: TIMEOUT_CYCLES must be at least 2");
  end

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   cur_write;
  logic   expired;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = M_AXI_LITE_AWVALID & M_AXI_LITE_AWREADY;
  assign w_hs  = M_AXI_LITE_WVALID  & M_AXI_LITE_WREADY;
  assign b_hs  = M_AXI_LITE_BVALID  & M_AXI_LITE_BREADY;
  assign ar_hs = M_AXI_LITE_ARVALID & M_AXI_LITE_ARREADY;
  assign r_hs  = M_AXI_LITE_RVALID  & M_AXI_LITE_RREADY;

  assign M_AXI_LITE_AWPROT = PROT_DEFAULT;
  assign M_AXI_LITE_ARPROT = PROT_DEFAULT;

`ifdef M_AXI_LITE_TIMEOUT_EN
  logic busy;
  logic any_hs;

  assign busy   = (state == ST_WR) || (state == ST_WR_RESP) ||
                  (state == ST_RD_ADDR) || (state == ST_RD_DATA);
  assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;

  m_axi_lite_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (M_AXI_ACLK),
    .rst_n   (M_AXI_ARESETN),
    .active  (busy),
    .clear   (any_hs),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state              <= ST_IDLE;
      aw_done            <= 1'b0;
      w_done             <= 1'b0;
      cur_write          <= 1'b0;
      cmd_ready          <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_write          <= 1'b0;
      rsp_rdata          <= '0;
      rsp_resp           <= RESP_OKAY;
      rsp_timeout        <= 1'b0;
      M_AXI_LITE_AWADDR  <= '0;
      M_AXI_LITE_AWVALID <= 1'b0;
      M_AXI_LITE_WDATA   <= '0;
      M_AXI_LITE_WSTRB   <= '0;
      M_AXI_LITE_WVALID  <= 1'b0;
      M_AXI_LITE_BREADY  <= 1'b0;
      M_AXI_LITE_ARADDR  <= '0;
      M_AXI_LITE_ARVALID <= 1'b0;
      M_AXI_LITE_RREADY  <= 1'b0;
    end else if (expired) begin
      // Watchdog abort: withdraw every request and report a synthetic SLVERR.
      M_AXI_LITE_AWVALID <= 1'b0;
      M_AXI_LITE_WVALID  <= 1'b0;
      M_AXI_LITE_BREADY  <= 1'b0;
      M_AXI_LITE_ARVALID <= 1'b0;
      M_AXI_LITE_RREADY  <= 1'b0;
      rsp_valid          <= 1'b1;
      rsp_write          <= cur_write;
      rsp_rdata          <= '0;
      rsp_resp           <= RESP_SLVERR;
      rsp_timeout        <= 1'b1;
      state              <= ST_RESP;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            cur_write <= cmd_write;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            if (cmd_write) begin
              M_AXI_LITE_AWADDR  <= cmd_addr;
              M_AXI_LITE_WDATA   <= cmd_wdata;
              M_AXI_LITE_WSTRB   <= cmd_wstrb;
              M_AXI_LITE_AWVALID <= 1'b1;
              M_AXI_LITE_WVALID  <= 1'b1;
              state              <= ST_WR;
            end else begin
              M_AXI_LITE_ARADDR  <= cmd_addr;
              M_AXI_LITE_ARVALID <= 1'b1;
              state              <= ST_RD_ADDR;
            end
          end
        end

        ST_WR: begin
          if (aw_hs) begin
            M_AXI_LITE_AWVALID <= 1'b0;
            aw_done            <= 1'b1;
          end
          if (w_hs) begin
            M_AXI_LITE_WVALID <= 1'b0;
            w_done            <= 1'b1;
          end
          // Count this cycle's handshakes so a same-cycle finish costs no extra clock.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            M_AXI_LITE_BREADY <= 1'b1;
            state             <= ST_WR_RESP;
          end
        end

        ST_WR_RESP: begin
          if (b_hs) begin
            M_AXI_LITE_BREADY <= 1'b0;
            rsp_valid         <= 1'b1;
            rsp_write         <= 1'b1;
            rsp_rdata         <= '0;
            rsp_resp          <= M_AXI_LITE_BRESP;
            rsp_timeout       <= 1'b0;
            state             <= ST_RESP;
          end
        end

        ST_RD_ADDR: begin
          if (ar_hs) begin
            M_AXI_LITE_ARVALID <= 1'b0;
            M_AXI_LITE_RREADY  <= 1'b1;
            state              <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (r_hs) begin
            M_AXI_LITE_RREADY <= 1'b0;
            rsp_valid         <= 1'b1;
            rsp_write         <= 1'b0;
            rsp_rdata         <= M_AXI_LITE_RDATA;
            rsp_resp          <= M_AXI_LITE_RRESP;
            rsp_timeout       <= 1'b0;
            state             <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_axi_lite_master.sv
// Bench for m_axi_lite_master: reactive AXI-Lite slave plus a word-memory reference model.
module tb_m_axi_lite_master;
  import m_axi_lite_pkg::*;

`ifdef M_AXI_LITE_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 256;
`endif

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int n_tests, n_fail, cyc;
  logic [31:0] ref_mem [int];
  logic [31:0] slv_mem [int];

  m_axi_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI_LITE_AWADDR(awaddr), .M_AXI_LITE_AWPROT(awprot),
    .M_AXI_LITE_AWVALID(awvalid), .M_AXI_LITE_AWREADY(awready),
    .M_AXI_LITE_WDATA(wdata), .M_AXI_LITE_WSTRB(wstrb),
    .M_AXI_LITE_WVALID(wvalid), .M_AXI_LITE_WREADY(wready),
    .M_AXI_LITE_BRESP(bresp), .M_AXI_LITE_BVALID(bvalid), .M_AXI_LITE_BREADY(bready),
    .M_AXI_LITE_ARADDR(araddr), .M_AXI_LITE_ARPROT(arprot),
    .M_AXI_LITE_ARVALID(arvalid), .M_AXI_LITE_ARREADY(arready),
    .M_AXI_LITE_RDATA(rdata), .M_AXI_LITE_RRESP(rresp),
    .M_AXI_LITE_RVALID(rvalid), .M_AXI_LITE_RREADY(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Untouched words read back as a fixed pattern of their address.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int k;
    k = int'(a[31:2]);
    return ref_mem.exists(k) ? ref_mem[k] : dflt(a);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    int k;
    k = int'(a[31:2]);
    return slv_mem.exists(k) ? slv_mem[k] : dflt(a);
  endfunction

  function automatic logic [63:0] ctl_outs();
    return 64'({cmd_ready, awvalid, wvalid, bready, arvalid, rready,
                rsp_valid, rsp_write, rsp_timeout, rsp_resp});
  endfunction

  // d0: AW/AR ready delay (-1 = never), d1: W ready delay, d2: B/R valid delay,
  // rd: rsp_ready delay. rst_mid pulses reset once the master is waiting on B.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input int d0, input int d1, input int d2,
                        input int rd, input logic [1:0] resp, input bit rst_mid);
    int n, acc, first, vcnt, a_cnt, w_cnt, x_cnt, r_cnt, a_hs, w_hs, x_hs, mx;
    bit a_done, w_done, x_done, got, fin, committed, rst_done, exp_to;
    logic [31:0] exp_rdata, s_addr, s_wdata, p_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  p_resp, exp_resp;
    logic        p_write, p_to;
    {vcnt, a_cnt, w_cnt, x_cnt, r_cnt, a_hs, w_hs, x_hs, first} = '0;
    {a_done, w_done, x_done, got, fin, committed, rst_done} = '0;
    {s_addr, s_wdata, p_rdata, s_wstrb, p_resp, p_write, p_to} = '0;
    mx = (d0 > d1) ? d0 : d1;
    exp_to = (d0 < 0);
    exp_resp = exp_to ? 2'b10 : resp;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("cmd_ready_wait", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
    acc = cyc + 1;
    if (wr) begin
      ref_mem[int'(addr[31:2])] = merge(ref_rd(addr), wd, strb);
      exp_rdata = '0;
    end else begin
      exp_rdata = ref_rd(addr);
    end
    for (int i = 0; i < 300 && !fin; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (rst_mid && bready && a_done && w_done) begin
        #2 rst_n = 1'b0;
        #1 check_eq("rst_async_ctl", ctl_outs(), 64'(0));
        check_eq("rst_async_data", {awaddr, wdata}, 64'(0));
        bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        #1 rst_n = 1'b1;
        fin = 1'b1;
        rst_done = 1'b1;
      end else begin
        if (cmd_ready) vcnt++;
        // response channel first: it only reacts to handshakes from earlier cycles
        if (wr) begin
          if (a_done && w_done && !x_done) begin
            bvalid = (x_cnt >= d2); bresp = resp; x_cnt++;
            if (bvalid && bready) begin x_done = 1'b1; x_hs++; end
          end else bvalid = 1'b0;
          if (awvalid) begin
            if (a_cnt == 0) begin
              check_eq("awaddr", 64'(awaddr), 64'(addr));
              check_eq("awprot", 64'(awprot), 64'(0));
            end else if (awaddr !== addr) vcnt++;
            awready = (a_cnt >= d0); a_cnt++;
            if (awready) begin a_hs++; a_done = 1'b1; s_addr = awaddr; end
          end else begin
            awready = 1'b0;
            if (a_cnt > 0 && !a_done) vcnt++;
          end
          if (wvalid) begin
            if (w_cnt == 0) begin
              check_eq("wdata", 64'(wdata), 64'(wd));
              check_eq("wstrb", 64'(wstrb), 64'(strb));
            end else if (wdata !== wd || wstrb !== strb) vcnt++;
            wready = (w_cnt >= d1); w_cnt++;
            if (wready) begin w_hs++; w_done = 1'b1; s_wdata = wdata; s_wstrb = wstrb; end
          end else begin
            wready = 1'b0;
            if (w_cnt > 0 && !w_done) vcnt++;
          end
          if (a_done && w_done && !committed) begin
            slv_mem[int'(s_addr[31:2])] = merge(slv_rd(s_addr), s_wdata, s_wstrb);
            committed = 1'b1;
          end
        end else begin
          if (a_done && !x_done) begin
            rvalid = (x_cnt >= d2); rresp = resp; rdata = slv_rd(s_addr); x_cnt++;
            if (rvalid && rready) begin x_done = 1'b1; x_hs++; end
          end else rvalid = 1'b0;
          if (arvalid) begin
            if (a_cnt == 0) begin
              check_eq("araddr", 64'(araddr), 64'(addr));
              check_eq("arprot", 64'(arprot), 64'(0));
            end else if (araddr !== addr) vcnt++;
            arready = (d0 >= 0) && (a_cnt >= d0); a_cnt++;
            if (arready) begin a_hs++; a_done = 1'b1; s_addr = araddr; end
          end else begin
            arready = 1'b0;
            if (a_cnt > 0 && !a_done && !exp_to) vcnt++;
          end
        end
        if (rsp_valid) begin
          if (!got) begin
            got = 1'b1; first = cyc;
            p_rdata = rsp_rdata; p_resp = rsp_resp; p_write = rsp_write; p_to = rsp_timeout;
          end else if ({rsp_rdata, rsp_resp, rsp_write, rsp_timeout} !==
                       {p_rdata, p_resp, p_write, p_to}) vcnt++;
          rsp_ready = (r_cnt >= rd); r_cnt++;
          if (rsp_ready) fin = 1'b1;
        end
      end
    end
    check_eq("txn_finished", 64'(fin), 64'(1));
    if (rst_mid) begin
      check_eq("rst_hit", 64'(rst_done), 64'(1));
    end else if (fin) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      check_eq("rsp_write", 64'(p_write), 64'(wr));
      check_eq("rsp_rdata", 64'(p_rdata), 64'(exp_rdata));
      check_eq("rsp_resp", 64'(p_resp), 64'(exp_resp));
      check_eq("rsp_timeout", 64'(p_to), 64'(exp_to));
      check_eq("rsp_dropped", 64'(rsp_valid), 64'(0));
      check_eq("cmd_ready_back", 64'(cmd_ready), 64'(1));
      check_eq("protocol", 64'(vcnt), 64'(0));
      if (exp_to) begin
        check_eq("arvalid_cycles", 64'(a_cnt), 64'(TO));
      end else begin
        check_eq("latency", 64'(first - acc), wr ? 64'(2 + mx + d2) : 64'(2 + d0 + d2));
        check_eq("addr_hs", 64'(a_hs), 64'(1));
        check_eq("resp_hs", 64'(x_hs), 64'(1));
        if (wr) check_eq("w_hs", 64'(w_hs), 64'(1));
      end
    end
  endtask

  initial begin
    int q;
    n_tests = 0; n_fail = 0; q = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    arready = 1'b0; rvalid = 1'b0; rresp = '0; rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ctl", ctl_outs(), 64'(0));
    check_eq("reset_data0", {awaddr, rsp_rdata}, 64'(0));
    check_eq("reset_data1", {wdata, araddr}, 64'(0));
    rst_n = 1'b1;
    #1 check_eq("cmd_ready_pre_edge", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    check_eq("cmd_ready_post_edge", 64'(cmd_ready), 64'(1));

    do_txn(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, 1'b0);
    do_txn(1'b1, 32'h08, 32'hCAFEF00D, 4'h5, 5, 0, 0, 0, 2'b00, 1'b0);
    slv_mem[4] = 32'h12345678;
    ref_mem[4] = 32'h12345678;
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 2'b10, 1'b0);
    do_txn(1'b0, 32'h04, 32'h0, 4'h0, 1, 0, 2, 4, 2'b00, 1'b0);
    do_txn(1'b1, 32'h20, 32'h0BAD0BAD, 4'hF, 0, 1, 6, 0, 2'b00, 1'b1);
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) q++;
    end
    check_eq("no_rsp_after_rst", 64'(q), 64'(0));
    do_txn(1'b1, 32'h20, 32'h600D600D, 4'hC, 0, 0, 0, 0, 2'b00, 1'b0);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 1'b0);
    do_txn(1'b1, 32'h0C, 32'h00000011, 4'hF, 2, 2, 1, 1, 2'b11, 1'b0);
    do_txn(1'b1, 32'h08, 32'h11223344, 4'hA, 0, 3, 0, 0, 2'b00, 1'b0);
`ifdef M_AXI_LITE_TIMEOUT_EN
    do_txn(1'b0, 32'h14, 32'h0, 4'h0, -1, 0, 0, 0, 2'b00, 1'b0);
`endif

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got expired expected finished");
    $fatal(1, "time limit");
  end

endmodule
